// File: rtl/ps2_key_event_ctrl_pkg.sv
// rtl/ps2_key_event_ctrl_pkg.sv - shared constants and types for the PS/2 key event sequencer
// Purpose: scan-code prefix values, prefix-decoder state encoding, event word layout.
// Ports: none (package).
package ps2_key_event_ctrl_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Event word layout: {Ext, Break, Code[7:0]}
    localparam int EVT_W       = 10;
    localparam int EVT_EXT_BIT = 9;
    localparam int EVT_BRK_BIT = 8;
    localparam int EVT_CODE_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXT    = 2'd1,
        ST_BRK    = 2'd2,
        ST_EXTBRK = 2'd3
    } state_t;

    function automatic logic [EVT_W-1:0] make_evt(input logic ext, input logic brk,
                                                  input logic [7:0] code);
        logic [EVT_W-1:0] e;
        e = '0;
        e[EVT_EXT_BIT]               = ext;
        e[EVT_BRK_BIT]               = brk;
        e[EVT_CODE_LO +: 8]          = code;
        return e;
    endfunction

endpackage

// File: rtl/ps2_key_event_ctrl_if.sv
// rtl/ps2_key_event_ctrl_if.sv - scan-byte input and key-event output bundle
// Purpose: groups the receiver-side byte stream and the consumer-side event stream.
// Ports (signals):
//   ScanByte/ScanValid/ScanErr : byte stream from the PS/2 frame receiver
//   EvtData/EvtValid/EvtReady  : key-event queue head with valid/ready handshake
//   Strobe/Overflow/ErrCount   : display strobe, sticky drop flag, error counter
// Modports: master = receiver + consumer side, slave = the sequencer.
interface ps2_key_event_ctrl_if;
    import ps2_key_event_ctrl_pkg::*;

    logic [7:0]       ScanByte;
    logic             ScanValid;
    logic             ScanErr;
    logic [EVT_W-1:0] EvtData;
    logic             EvtValid;
    logic             EvtReady;
    logic             Strobe;
    logic             Overflow;
    logic [7:0]       ErrCount;

    modport master (
        output ScanByte, ScanValid, ScanErr, EvtReady,
        input  EvtData, EvtValid, Strobe, Overflow, ErrCount
    );

    modport slave (
        input  ScanByte, ScanValid, ScanErr, EvtReady,
        output EvtData, EvtValid, Strobe, Overflow, ErrCount
    );

endinterface

// File: rtl/ps2_key_event_ctrl_evt_fifo.sv
// rtl/ps2_key_event_ctrl_evt_fifo.sv - synchronous count-based event FIFO with sticky overflow
// Purpose: holds key events until the consumer takes them.
// Ports:
//   Clk, Reset_n          : clock, synchronous active-low reset
//   push, push_data       : write request and word
//   pop_req               : consumer ready; ignored while empty
//   head_data, valid      : head entry (combinational from storage), non-empty flag
//   overflow              : sticky, set when a push is dropped because the FIFO is full
module ps2_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic             overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop_req & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr];
    assign valid     = ~empty;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// rtl/ps2_key_event_ctrl.sv - PS/2 scan-code prefix decoder, repeat filter, event queue and strobe
// Purpose: turns received scan bytes into {Ext, Break, Code} key events, drops typematic
//   repeats of the held key, queues events, and stretches each accepted make into Strobe.
// Ports:
//   Clk, Reset_n : clock, synchronous active-low reset
//   bus (slave)  : ScanByte/ScanValid/ScanErr in, EvtData/EvtValid/EvtReady event
//                  handshake, Strobe, Overflow (sticky), ErrCount (saturating)
module ps2_key_event_ctrl
    import ps2_key_event_ctrl_pkg::*;
#(
    parameter int STROBE_CYCLES   = 10_000_000,
    parameter int FIFO_DEPTH      = 4,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    ps2_key_event_ctrl_if.slave  bus
);

    localparam int              CW          = $clog2(STROBE_CYCLES + 1);
    localparam logic [CW-1:0]   STROBE_LOAD = CW'(STROBE_CYCLES);

    state_t           state;
    state_t           state_nx;
    logic             emit;
    logic             e_ext;
    logic             e_brk;
    logic             proto_err;
    logic             matches_held;
    logic             suppress;
    logic             accept;
    logic             count_err;

    logic             held_valid;
    logic             held_ext;
    logic [7:0]       held_code;
    logic             push_q;
    logic [EVT_W-1:0] push_data_q;
    logic [CW-1:0]    strobe_cnt;
    logic [7:0]       err_cnt;

    // Prefix decode for the byte presented this cycle.
    always_comb begin
        state_nx  = state;
        emit      = 1'b0;
        e_ext     = 1'b0;
        e_brk     = 1'b0;
        proto_err = 1'b0;
        if (bus.ScanValid) begin
            if (bus.ScanErr) begin
                state_nx = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.ScanByte == SC_EXT)      state_nx = ST_EXT;
                        else if (bus.ScanByte == SC_BRK) state_nx = ST_BRK;
                        else                             emit     = 1'b1;
                    end
                    ST_EXT: begin
                        if (bus.ScanByte == SC_BRK) begin
                            state_nx = ST_EXTBRK;
                        end else begin
                            state_nx  = ST_IDLE;
                            proto_err = (bus.ScanByte == SC_EXT);
                            emit      = (bus.ScanByte != SC_EXT);
                            e_ext     = 1'b1;
                        end
                    end
                    ST_BRK, ST_EXTBRK: begin
                        state_nx  = ST_IDLE;
                        proto_err = (bus.ScanByte == SC_EXT) || (bus.ScanByte == SC_BRK);
                        emit      = !proto_err;
                        e_ext     = (state == ST_EXTBRK);
                        e_brk     = 1'b1;
                    end
                    default: state_nx = ST_IDLE;
                endcase
            end
        end
    end

    assign matches_held = held_valid && (held_ext == e_ext) && (held_code == bus.ScanByte);
    assign suppress     = (SUPPRESS_REPEAT != 0) && emit && !e_brk && matches_held;
    assign accept       = emit && !suppress;
    assign count_err    = bus.ScanValid && (bus.ScanErr || proto_err);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            held_valid  <= 1'b0;
            held_ext    <= 1'b0;
            held_code   <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            strobe_cnt  <= '0;
            err_cnt     <= '0;
        end else begin
            state       <= state_nx;
            // Push is staged one cycle so the FIFO write lands on the following edge.
            push_q      <= accept;
            push_data_q <= make_evt(e_ext, e_brk, bus.ScanByte);
            if (accept && !e_brk) begin
                held_valid <= 1'b1;
                held_ext   <= e_ext;
                held_code  <= bus.ScanByte;
                strobe_cnt <= STROBE_LOAD;
            end else begin
                if (accept && e_brk && matches_held) begin
                    held_valid <= 1'b0;
                end
                if (strobe_cnt != '0) begin
                    strobe_cnt <= strobe_cnt - 1'b1;
                end
            end
            if (count_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    ps2_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .push      (push_q),
        .push_data (push_data_q),
        .pop_req   (bus.EvtReady),
        .head_data (bus.EvtData),
        .valid     (bus.EvtValid),
        .overflow  (bus.Overflow)
    );

    assign bus.Strobe   = (strobe_cnt != '0);
    assign bus.ErrCount = err_cnt;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb/tb_ps2_key_event_ctrl.sv - self-checking bench for ps2_key_event_ctrl
module tb_ps2_key_event_ctrl;

    localparam int STROBE = 6;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [7:0] b;
        logic       err;
        logic       has_evt;
        logic [9:0] evt;
        logic [7:0] exp_err;
    } vec_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    int   strobe_hi;
    logic [9:0] exp_q[$];
    vec_t tbl[25];

    ps2_key_event_ctrl_if bus();

    ps2_key_event_ctrl #(
        .STROBE_CYCLES   (STROBE),
        .FIFO_DEPTH      (DEPTH),
        .SUPPRESS_REPEAT (1)
    ) dut (
        .Clk     (clk),
        .Reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every handshake against the oldest expected event.
    always @(negedge clk) begin
        if (strobe_hi >= 0 && bus.Strobe === 1'b1) strobe_hi++;
        if (reset_n && bus.EvtValid === 1'b1 && bus.EvtReady === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual=0x%0h required=none", bus.EvtData);
            end else begin
                chk("event", 32'(bus.EvtData), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic err);
        @(posedge clk); #1;
        bus.ScanByte  = b;
        bus.ScanErr   = err;
        bus.ScanValid = 1'b1;
        @(posedge clk); #1;
        bus.ScanValid = 1'b0;
        bus.ScanErr   = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic vec_t mk(input logic [7:0] b, input logic err, input logic h,
                                input logic [9:0] e, input logic [7:0] ec);
        vec_t v;
        v.b = b; v.err = err; v.has_evt = h; v.evt = e; v.exp_err = ec;
        return v;
    endfunction

    initial begin
        checks = 0; failures = 0; strobe_hi = 0;
        reset_n = 1'b0;
        bus.ScanByte = 8'h00; bus.ScanValid = 1'b0; bus.ScanErr = 1'b0; bus.EvtReady = 1'b1;

        tbl[0]  = mk(8'h1C, 0, 1, 10'h01C, 0);
        tbl[1]  = mk(8'hF0, 0, 0, 10'h000, 0);
        tbl[2]  = mk(8'h1C, 0, 1, 10'h11C, 0);
        tbl[3]  = mk(8'hE0, 0, 0, 10'h000, 0);
        tbl[4]  = mk(8'h75, 0, 1, 10'h275, 0);
        tbl[5]  = mk(8'hE0, 0, 0, 10'h000, 0);
        tbl[6]  = mk(8'hF0, 0, 0, 10'h000, 0);
        tbl[7]  = mk(8'h75, 0, 1, 10'h375, 0);
        tbl[8]  = mk(8'h1C, 0, 1, 10'h01C, 0);
        tbl[9]  = mk(8'h1C, 0, 0, 10'h000, 0);
        tbl[10] = mk(8'h1C, 0, 0, 10'h000, 0);
        tbl[11] = mk(8'hF0, 0, 0, 10'h000, 0);
        tbl[12] = mk(8'h1C, 0, 1, 10'h11C, 0);
        tbl[13] = mk(8'h1C, 0, 1, 10'h01C, 0);
        tbl[14] = mk(8'h1C, 0, 0, 10'h000, 0);
        tbl[15] = mk(8'hF0, 0, 0, 10'h000, 0);
        tbl[16] = mk(8'h1C, 0, 1, 10'h11C, 0);
        tbl[17] = mk(8'hF0, 1, 0, 10'h000, 1);
        tbl[18] = mk(8'h1C, 0, 1, 10'h01C, 1);
        tbl[19] = mk(8'hE0, 0, 0, 10'h000, 1);
        tbl[20] = mk(8'hE0, 0, 0, 10'h000, 2);
        tbl[21] = mk(8'h75, 0, 1, 10'h075, 2);
        tbl[22] = mk(8'hF0, 0, 0, 10'h000, 2);
        tbl[23] = mk(8'hE0, 0, 0, 10'h000, 3);
        tbl[24] = mk(8'h1C, 0, 1, 10'h01C, 3);

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_evtvalid", 32'(bus.EvtValid), 0);
        chk("rst_evtdata",  32'(bus.EvtData),  0);
        chk("rst_strobe",   32'(bus.Strobe),   0);
        chk("rst_overflow", 32'(bus.Overflow), 0);
        chk("rst_errcount", 32'(bus.ErrCount), 0);

        // Table: byte stream with expected events and cumulative error count.
        for (int i = 0; i < 25; i++) begin
            if (tbl[i].has_evt) exp_q.push_back(tbl[i].evt);
            send_byte(tbl[i].b, tbl[i].err);
            chk($sformatf("errcount_%0d", i), 32'(bus.ErrCount), 32'(tbl[i].exp_err));
        end
        wait_drain();
        chk("tbl_overflow", 32'(bus.Overflow), 0);

        // Latency and strobe length for a single make.
        repeat (20) @(posedge clk);
        strobe_hi = 0;
        exp_q.push_back(10'h02B);
        send_byte(8'h2B, 0);
        chk("lat_not_yet", 32'(bus.EvtValid), 0);
        @(posedge clk); #1;
        chk("lat_valid", 32'(bus.EvtValid), 1);
        repeat (20) @(posedge clk);
        chk("strobe_len", 32'(strobe_hi), 32'(STROBE));

        // A break never touches the strobe.
        strobe_hi = 0;
        exp_q.push_back(10'h12B);
        send_byte(8'hF0, 0);
        send_byte(8'h2B, 0);
        repeat (10) @(posedge clk);
        chk("brk_no_strobe", 32'(strobe_hi), 0);

        // Retrigger: second make 5 edges after the first reloads the counter.
        strobe_hi = 0;
        exp_q.push_back(10'h033);
        exp_q.push_back(10'h044);
        send_byte(8'h33, 0);
        repeat (3) @(posedge clk);
        send_byte(8'h44, 0);
        repeat (20) @(posedge clk);
        chk("strobe_retrig", 32'(strobe_hi), 32'(5 + STROBE));
        wait_drain();

        // Overflow: consumer stalled, five makes into a depth-4 queue.
        bus.EvtReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < DEPTH) exp_q.push_back(10'(8'h51 + i));
            send_byte(8'(8'h51 + i), 0);
        end
        repeat (4) @(posedge clk); #1;
        chk("ovf_flag",  32'(bus.Overflow), 1);
        chk("ovf_valid", 32'(bus.EvtValid), 1);
        chk("ovf_head",  32'(bus.EvtData),  32'h051);
        @(posedge clk); #1;
        bus.EvtReady = 1'b1;
        wait_drain();
        chk("ovf_sticky", 32'(bus.Overflow), 1);

        // Reset in the middle of an E0 prefix and during a strobe.
        exp_q.push_back(10'h061);
        send_byte(8'h61, 0);
        send_byte(8'hE0, 0);
        chk("pre_rst_strobe", 32'(bus.Strobe), 1);
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        chk("mrst_evtvalid", 32'(bus.EvtValid), 0);
        chk("mrst_evtdata",  32'(bus.EvtData),  0);
        chk("mrst_strobe",   32'(bus.Strobe),   0);
        chk("mrst_overflow", 32'(bus.Overflow), 0);
        chk("mrst_errcount", 32'(bus.ErrCount), 0);
        chk("mrst_pending",  32'(exp_q.size()), 0);
        exp_q.push_back(10'h075);
        send_byte(8'h75, 0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
